// File: rtl/pc_trace_ctrl_pkg.sv
// rtl/pc_trace_ctrl_pkg.sv - shared constants for the PC trace controller
// Contents:
//   ST_IDLE/ST_ARMED/ST_POST/ST_DUMP  2-bit FSM encodings, also driven on the state port
//   DEFAULT_XLEN                      default PC width
package pc_trace_ctrl_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_POST  = 2'd2;
  localparam logic [1:0] ST_DUMP  = 2'd3;

  localparam int DEFAULT_XLEN = 32;

endpackage

// File: rtl/pc_trace_ctrl_trace_ram.sv
// rtl/pc_trace_ctrl_trace_ram.sv - DEPTH x XLEN trace storage, sync write, async read
// Ports:
//   clk    in   clock for the write port
//   we     in   write enable
//   waddr  in   write address
//   wdata  in   write data
//   raddr  in   read address
//   rdata  out  mem[raddr], combinational
// Contents are not reset.
module trace_ram #(
  parameter int DEPTH = 16,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr,
  output logic [XLEN-1:0] rdata
);

  logic [XLEN-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pc_trace_ctrl.sv
// rtl/pc_trace_ctrl.sv - retired-PC trace buffer with breakpoint stop and host drain
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   pc, pc_valid         retired-PC sample stream
//   arm                  pulse: start or restart capture
//   bp_en, bp_addr       breakpoint compare
//   post_count           samples kept after the trigger sample (sampled on trigger)
//   rd_ready             host accepts rd_data
//   rd_valid/rd_data/rd_last  drain stream, oldest entry first
//   halt_req             high throughout DUMP
//   triggered            breakpoint hit since last arm, cleared when the dump finishes
//   state                IDLE=0 ARMED=1 POST=2 DUMP=3
import pc_trace_ctrl_pkg::*;

module pc_trace_ctrl #(
  parameter int DEPTH  = 16,
  parameter int XLEN   = DEFAULT_XLEN,
  parameter int PCNT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc,
  input  logic              pc_valid,
  input  logic              arm,
  input  logic              bp_en,
  input  logic [XLEN-1:0]   bp_addr,
  input  logic [PCNT_W-1:0] post_count,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [XLEN-1:0]   rd_data,
  output logic              rd_last,
  output logic              halt_req,
  output logic              triggered,
  output logic [1:0]        state
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic [PCNT_W-1:0] post_cnt;
  logic [XLEN-1:0]   ram_rdata;
  logic              hit;
  logic              write;
  logic              in_dump;

  assign in_dump = (state == ST_DUMP);
  assign hit     = pc_valid & bp_en & (pc == bp_addr);
  // The arm cycle of a restart in ARMED stores nothing.
  assign write   = pc_valid & (((state == ST_ARMED) & ~arm) | (state == ST_POST));
  // Oldest entry sits count slots behind the write pointer; when full
  // (count == DEPTH) the low bits are zero and rd_ptr == wr_ptr.
  assign rd_ptr  = wr_ptr - count[AW-1:0];

  assign halt_req = in_dump;
  assign rd_valid = in_dump;
  assign rd_data  = in_dump ? ram_rdata : '0;
  assign rd_last  = in_dump & (count == ONE);

  trace_ram #(
    .DEPTH (DEPTH),
    .XLEN  (XLEN)
  ) u_ram (
    .clk   (clk),
    .we    (write),
    .waddr (wr_ptr),
    .wdata (pc),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      wr_ptr    <= '0;
      count     <= '0;
      post_cnt  <= '0;
      triggered <= 1'b0;
    end else begin
      if (write) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (count != FULL) begin
          count <= count + 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (arm) begin
            state  <= ST_ARMED;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
        ST_ARMED: begin
          if (arm) begin
            wr_ptr <= '0;
            count  <= '0;
          end else if (hit) begin
            triggered <= 1'b1;
            if (post_count == '0) begin
              state <= ST_DUMP;
            end else begin
              state    <= ST_POST;
              post_cnt <= post_count;
            end
          end
        end
        ST_POST: begin
          if (pc_valid) begin
            post_cnt <= post_cnt - 1'b1;
            if (post_cnt == PCNT_W'(1)) begin
              state <= ST_DUMP;
            end
          end
        end
        ST_DUMP: begin
          if (rd_ready) begin
            count <= count - 1'b1;
            if (count == ONE) begin
              state     <= ST_IDLE;
              triggered <= 1'b0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_trace_ctrl.sv
// tb/tb_pc_trace_ctrl.sv - self-checking bench for pc_trace_ctrl against a queue-based trace model
module tb_pc_trace_ctrl;

  localparam int DEPTH  = 16;
  localparam int XLEN   = 32;
  localparam int PCNT_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [XLEN-1:0]   pc = '0;
  logic              pc_valid = 1'b0;
  logic              arm = 1'b0;
  logic              bp_en = 1'b0;
  logic [XLEN-1:0]   bp_addr = '0;
  logic [PCNT_W-1:0] post_count = '0;
  logic              rd_ready = 1'b0;
  logic              rd_valid;
  logic [XLEN-1:0]   rd_data;
  logic              rd_last;
  logic              halt_req;
  logic              triggered;
  logic [1:0]        state;

  int compared = 0;
  int mismatched = 0;
  logic [XLEN-1:0] exp_q[$];

  pc_trace_ctrl #(
    .DEPTH  (DEPTH),
    .XLEN   (XLEN),
    .PCNT_W (PCNT_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pc         (pc),
    .pc_valid   (pc_valid),
    .arm        (arm),
    .bp_en      (bp_en),
    .bp_addr    (bp_addr),
    .post_count (post_count),
    .rd_ready   (rd_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_last    (rd_last),
    .halt_req   (halt_req),
    .triggered  (triggered),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 32'(state), 32'd0);
    chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
    chk({tag, "_rd_data"}, rd_data, 32'd0);
    chk({tag, "_rd_last"}, 32'(rd_last), 32'd0);
    chk({tag, "_halt_req"}, 32'(halt_req), 32'd0);
    chk({tag, "_triggered"}, 32'(triggered), 32'd0);
  endtask

  // One capture+dump. Samples carry pc = n<<3; the model keeps every stored
  // sample since the last arm, trimmed to the newest DEPTH, and stops after
  // the hit sample plus pcnt further valid samples.
  task automatic run(input string tag, input int start_n, input int hit_n, input int pcnt,
                     input bit gaps, input bit rand_rdy, input int restart_n, input int abort_at);
    int cur_n;
    int remain;
    int budget;
    int i;
    bit hit_done;
    bit hit_prev;
    bit done;
    @(negedge clk);
    exp_q.delete();
    bp_en = 1'b1;
    bp_addr = XLEN'(hit_n) << 3;
    post_count = PCNT_W'(pcnt);
    arm = 1'b1;
    pc_valid = 1'b1;
    pc = XLEN'(start_n) << 3;
    cur_n = start_n + 1;
    hit_done = 1'b0;
    done = 1'b0;
    remain = 0;
    budget = 0;
    while (!done && budget < 2000) begin
      @(negedge clk);
      budget++;
      hit_prev = hit_done;
      arm = 1'b0;
      pc_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      if (!pc_valid) begin
        pc = bp_addr;
      end else begin
        pc = XLEN'(cur_n) << 3;
        if (!hit_done && cur_n == restart_n) begin
          arm = 1'b1;
          exp_q.delete();
        end else begin
          exp_q.push_back(pc);
          if (exp_q.size() > DEPTH) void'(exp_q.pop_front());
          if (hit_done) begin
            remain--;
            if (remain == 0) done = 1'b1;
          end else if (cur_n == hit_n) begin
            hit_done = 1'b1;
            remain = pcnt;
            if (pcnt == 0) done = 1'b1;
          end
        end
        cur_n++;
      end
      if (hit_prev && gaps) arm = 1'($urandom_range(1));
    end
    chk({tag, "_capture_done"}, 32'(done), 32'd1);
    @(negedge clk);
    chk({tag, "_dump_state"}, 32'(state), 32'd3);
    chk({tag, "_dump_halt"}, 32'(halt_req), 32'd1);
    chk({tag, "_dump_trig"}, 32'(triggered), 32'd1);
    i = 0;
    budget = 0;
    while (i < exp_q.size() && budget < 2000) begin
      if (abort_at == i) begin
        rst = 1'b1;
        #1;
        chk_idle({tag, "_abort"});
        @(negedge clk);
        chk_idle({tag, "_abort_hold"});
        rst = 1'b0;
        rd_ready = 1'b0;
        arm = 1'b0;
        pc_valid = 1'b0;
        return;
      end
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
      chk({tag, "_rd_data"}, rd_data, exp_q[i]);
      chk({tag, "_rd_last"}, 32'(rd_last), 32'(i == exp_q.size() - 1));
      rd_ready = rand_rdy ? 1'($urandom_range(1)) : 1'b1;
      pc_valid = 1'b1;
      pc = XLEN'(cur_n) << 3;
      cur_n++;
      arm = 1'($urandom_range(1));
      @(negedge clk);
      budget++;
      if (rd_ready) i++;
    end
    chk({tag, "_drain_count"}, 32'(i), 32'(exp_q.size()));
    rd_ready = 1'b0;
    arm = 1'b0;
    pc_valid = 1'b0;
    chk_idle({tag, "_end"});
  endtask

  initial begin
    rst = 1'b1;
    repeat (5) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;

    run("nowrap",    2,  5, 2, 1'b0, 1'b0, -1, -1);
    run("wrap",      0, 40, 3, 1'b0, 1'b0, -1, -1);
    run("post0",     0, 16, 0, 1'b0, 1'b0, -1, -1);
    run("backpress", 0, 10, 4, 1'b0, 1'b1, -1, -1);
    run("restart",   0, 12, 1, 1'b1, 1'b1,  5, -1);
    run("abort",     0, 20, 2, 1'b0, 1'b1, -1,  3);
    run("after_abort", 3, 9, 1, 1'b0, 1'b0, -1, -1);

    for (int k = 0; k < 6; k++) begin
      int s;
      int h;
      s = int'($urandom_range(20));
      h = s + 1 + int'($urandom_range(39));
      run($sformatf("rand%0d", k), s, h, int'($urandom_range(20)), 1'b1, 1'b1,
          (k % 2 == 1 && h > s + 2) ? s + 1 : -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
